fpu_issue_scoreboard: RTL and testbench

//  Issue controller in front of the FPU pipeline. Accepts 17-bit instructions, splits them into
//  RL[16:12] RR[11:7] RD[6:2] Op[1:0], and tracks destination registers in flight. Releases an

---
 rtl/fpu_issue_scoreboard.sv | 115 +++++++++++
 tb/tb_fpu_issue_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_scoreboard.sv
// FPU issue scoreboard: one-deep head register, RAW/WAW hazard and outstanding-limit gating.
// Optional macro FPU_SB_STATS_EN adds the saturating stall_cycles counter port.
module fpu_issue_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [16:0]   in_inst,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [4:0]    iss_rl,
  output logic [4:0]    iss_rr,
  output logic [4:0]    iss_rd,
  output logic [1:0]    iss_op,
  input  logic          wb_valid,
  input  logic [4:0]    wb_rd,
  output logic [31:0]   busy_vec,
  output logic [CW-1:0] outstanding,
  output logic          sb_err
`ifdef FPU_SB_STATS_EN
  ,
  output logic [15:0]   stall_cycles
`endif
);

  localparam logic [CW:0] MAX_L = MAX_OUT[CW:0];

  logic          head_vld_q, head_vld_d;
  logic [16:0]   head_q, head_d;
  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] out_q, out_d;
  logic          err_q, err_d;

  logic [31:0]   rel, eff_busy, set_vec;
  logic          wb_hit, hazard, room, issue, accept;
  logic [CW:0]   out_eff;

  assign rel      = wb_valid ? (32'd1 << wb_rd) : 32'd0;
  assign eff_busy = busy_q & ~rel;
  assign wb_hit   = wb_valid && busy_q[wb_rd];

  assign hazard  = eff_busy[head_q[16:12]] | eff_busy[head_q[11:7]] | eff_busy[head_q[6:2]];
  // A writeback retiring this cycle frees its slot for a same-cycle issue.
  assign out_eff = {1'b0, out_q} - {{CW{1'b0}}, wb_hit};
  assign room    = out_eff < MAX_L;

  assign iss_valid = head_vld_q && !hazard && room;
  assign issue     = iss_valid && iss_ready;
  assign in_ready  = !head_vld_q || issue;
  assign accept    = in_valid && in_ready;

  assign set_vec = issue ? (32'd1 << head_q[6:2]) : 32'd0;

  always_comb begin
    head_vld_d = head_vld_q;
    head_d     = head_q;
    if (accept) begin
      head_vld_d = 1'b1;
      head_d     = in_inst;
    end else if (issue) begin
      head_vld_d = 1'b0;
      head_d     = 17'd0;
    end

    busy_d = eff_busy | set_vec;

    out_d = out_q;
    if (issue && !wb_hit)      out_d = out_q + CW'(1);
    else if (!issue && wb_hit) out_d = out_q - CW'(1);

    err_d = err_q | (wb_valid && !busy_q[wb_rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vld_q <= 1'b0;
      head_q     <= 17'd0;
      busy_q     <= 32'd0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  assign iss_rl      = head_q[16:12];
  assign iss_rr      = head_q[11:7];
  assign iss_rd      = head_q[6:2];
  assign iss_op      = head_q[1:0];
  assign busy_vec    = busy_q;
  assign outstanding = out_q;
  assign sb_err      = err_q;

`ifdef FPU_SB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
    end else if (head_vld_q && !iss_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Directed bench for fpu_issue_scoreboard; stall counter checks built when FPU_SB_STATS_EN is defined.
module tb_fpu_issue_scoreboard;

  logic        clk, rst_n, in_valid, in_ready, iss_valid, iss_ready, wb_valid, sb_err;
  logic [16:0] in_inst;
  logic [4:0]  iss_rl, iss_rr, iss_rd, wb_rd;
  logic [1:0]  iss_op;
  logic [31:0] busy_vec;
  logic [2:0]  outstanding;
`ifdef FPU_SB_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fpu_issue_scoreboard #(.MAX_OUT(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rl(iss_rl), .iss_rr(iss_rr), .iss_rd(iss_rd), .iss_op(iss_op),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy_vec(busy_vec), .outstanding(outstanding), .sb_err(sb_err)
`ifdef FPU_SB_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] mk(input logic [4:0] rl, input logic [4:0] rr,
                                     input logic [4:0] rd, input logic [1:0] op);
    return {rl, rr, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; iss_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
    #12;
    n_cmp++; if (busy_vec !== 32'd0) begin n_err++; $display("FAIL reset_busy got %0h exp 0", busy_vec); end
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_out got %0d exp 0", outstanding); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL reset_iss_valid got %b exp 0", iss_valid); end
    n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL reset_sb_err got %b exp 0", sb_err); end
    n_cmp++; if ({iss_rl, iss_rr, iss_rd, iss_op} !== 17'd0) begin n_err++; $display("FAIL reset_fields got %0h exp 0", {iss_rl, iss_rr, iss_rd, iss_op}); end
`ifdef FPU_SB_STATS_EN
    n_cmp++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
`endif
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    in_inst = mk(5'd20, 5'd21, 5'd3, 2'd1); in_valid = 1'b1; #1;
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL raw_empty_valid got %b exp 0", iss_valid); end
    tick();
    in_inst = mk(5'd3, 5'd12, 5'd13, 2'd2); #1;
    n_cmp++; if (iss_valid !== 1'b1 || iss_rd !== 5'd3) begin n_err++; $display("FAIL raw_first_issue got v=%b rd=%0d exp v=1 rd=3", iss_valid, iss_rd); end
    tick();
    in_valid = 1'b0; #1;
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL raw_hazard_valid got %b exp 0", iss_valid); end
    n_cmp++; if (iss_rl !== 5'd3 || in_ready !== 1'b0) begin n_err++; $display("FAIL raw_held got rl=%0d rdy=%b exp rl=3 rdy=0", iss_rl, in_ready); end
    n_cmp++; if (busy_vec !== 32'h8 || outstanding !== 3'd1) begin n_err++; $display("FAIL raw_busy got %0h/%0d exp 8/1", busy_vec, outstanding); end
    tick(); tick();
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL raw_hold got %b exp 0", iss_valid); end
    wb_valid = 1'b1; wb_rd = 5'd3; #1;
    n_cmp++; if (iss_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL raw_wb_release got v=%b rdy=%b exp 1/1", iss_valid, in_ready); end
    tick();
    wb_rd = 5'd13; #1;
    n_cmp++; if (busy_vec !== 32'h2000 || outstanding !== 3'd1) begin n_err++; $display("FAIL raw_after got %0h/%0d exp 2000/1", busy_vec, outstanding); end
    tick();
    wb_valid = 1'b0; #1;
    n_cmp++; if (busy_vec !== 32'd0 || outstanding !== 3'd0) begin n_err++; $display("FAIL raw_drain got %0h/%0d exp 0/0", busy_vec, outstanding); end
  endtask

  task automatic test_limit();
    for (int i = 1; i <= 5; i++) begin
      in_inst = mk(5'd30, 5'd31, 5'(i), 2'd0); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; #1;
    n_cmp++; if (outstanding !== 3'd4 || busy_vec !== 32'h1E) begin n_err++; $display("FAIL limit_full got %0d/%0h exp 4/1e", outstanding, busy_vec); end
    n_cmp++; if (iss_valid !== 1'b0 || iss_rd !== 5'd5 || in_ready !== 1'b0) begin n_err++; $display("FAIL limit_stall got v=%b rd=%0d rdy=%b exp 0/5/0", iss_valid, iss_rd, in_ready); end
    tick();
    n_cmp++; if (iss_valid !== 1'b0 || outstanding !== 3'd4) begin n_err++; $display("FAIL limit_hold got v=%b out=%0d exp 0/4", iss_valid, outstanding); end
    wb_valid = 1'b1; wb_rd = 5'd1; #1;
    n_cmp++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL limit_wb_room got %b exp 1", iss_valid); end
    tick();
    wb_valid = 1'b0; #1;
    n_cmp++; if (outstanding !== 3'd4 || busy_vec !== 32'h3C || iss_valid !== 1'b0) begin n_err++; $display("FAIL limit_after got %0d/%0h/%b exp 4/3c/0", outstanding, busy_vec, iss_valid); end
    for (int r = 2; r <= 5; r++) begin
      wb_valid = 1'b1; wb_rd = 5'(r);
      tick();
    end
    wb_valid = 1'b0; #1;
    n_cmp++; if (outstanding !== 3'd0 || busy_vec !== 32'd0) begin n_err++; $display("FAIL limit_drain got %0d/%0h exp 0/0", outstanding, busy_vec); end
  endtask

  task automatic test_same_cycle();
    in_inst = mk(5'd7, 5'd7, 5'd7, 2'd3); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    n_cmp++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL same_regs_legal got %b exp 1", iss_valid); end
    tick();
    in_inst = mk(5'd8, 5'd9, 5'd7, 2'd1); in_valid = 1'b1; #1;
    n_cmp++; if (busy_vec !== 32'h80 || outstanding !== 3'd1) begin n_err++; $display("FAIL same_first got %0h/%0d exp 80/1", busy_vec, outstanding); end
    tick();
    in_valid = 1'b0; #1;
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL same_waw got %b exp 0", iss_valid); end
    wb_valid = 1'b1; wb_rd = 5'd7; #1;
    n_cmp++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL same_wb_release got %b exp 1", iss_valid); end
    tick();
    wb_valid = 1'b0; #1;
    n_cmp++; if (busy_vec !== 32'h80 || outstanding !== 3'd1) begin n_err++; $display("FAIL same_set_wins got %0h/%0d exp 80/1", busy_vec, outstanding); end
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    wb_valid = 1'b0; #1;
    n_cmp++; if (busy_vec !== 32'd0 || outstanding !== 3'd0) begin n_err++; $display("FAIL same_drain got %0h/%0d exp 0/0", busy_vec, outstanding); end
  endtask

  task automatic test_backpressure();
    iss_ready = 1'b0;
    in_inst = mk(5'd1, 5'd2, 5'd6, 2'd2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_inst = mk(5'd9, 5'd9, 5'd9, 2'd1); #1;
    n_cmp++; if (iss_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_held got v=%b rdy=%b exp 1/0", iss_valid, in_ready); end
    tick(); tick();
    n_cmp++; if ({iss_rl, iss_rr, iss_rd, iss_op} !== mk(5'd1, 5'd2, 5'd6, 2'd2) || iss_valid !== 1'b1 || busy_vec !== 32'd0) begin n_err++; $display("FAIL bp_stable got %0h v=%b busy=%0h exp %0h v=1 busy=0", {iss_rl, iss_rr, iss_rd, iss_op}, iss_valid, busy_vec, mk(5'd1, 5'd2, 5'd6, 2'd2)); end
    iss_ready = 1'b1;
    tick();
    n_cmp++; if (busy_vec !== 32'h40 || outstanding !== 3'd1 || iss_valid !== 1'b0) begin n_err++; $display("FAIL bp_issue got %0h/%0d/%b exp 40/1/0", busy_vec, outstanding, iss_valid); end
    wb_valid = 1'b1; wb_rd = 5'd6;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_sb_err();
    wb_valid = 1'b1; wb_rd = 5'd9; #1;
    n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL err_before got %b exp 0", sb_err); end
    tick();
    wb_valid = 1'b0; #1;
    n_cmp++; if (sb_err !== 1'b1 || busy_vec !== 32'd0 || outstanding !== 3'd0) begin n_err++; $display("FAIL err_set got %b/%0h/%0d exp 1/0/0", sb_err, busy_vec, outstanding); end
    tick(); tick();
    n_cmp++; if (sb_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b exp 1", sb_err); end
  endtask

  task automatic test_reset_mid();
    in_inst = mk(5'd10, 5'd11, 5'd4, 2'd0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (outstanding !== 3'd1 || busy_vec !== 32'h10) begin n_err++; $display("FAIL mid_inflight got %0d/%0h exp 1/10", outstanding, busy_vec); end
    rst_n = 1'b0; #1;
    n_cmp++; if (busy_vec !== 32'd0 || outstanding !== 3'd0 || sb_err !== 1'b0 || iss_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset got %0h/%0d/%b/%b exp 0/0/0/0", busy_vec, outstanding, sb_err, iss_valid); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd4;
    tick();
    wb_valid = 1'b0; #1;
    n_cmp++; if (sb_err !== 1'b1 || outstanding !== 3'd0) begin n_err++; $display("FAIL mid_late_wb got %b/%0d exp 1/0", sb_err, outstanding); end
  endtask

`ifdef FPU_SB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; #2;
    @(negedge clk); rst_n = 1'b1;
    tick();
    in_inst = mk(5'd20, 5'd21, 5'd3, 2'd0); in_valid = 1'b1;
    tick();
    in_inst = mk(5'd3, 5'd5, 5'd6, 2'd0);
    tick();
    in_valid = 1'b0; #1;
    n_cmp++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL stats_start got %0d exp 0", stall_cycles); end
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (stall_cycles !== 16'd10) begin n_err++; $display("FAIL stats_raw got %0d exp 10", stall_cycles); end
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    wb_valid = 1'b0; #1;
    n_cmp++; if (stall_cycles !== 16'd10) begin n_err++; $display("FAIL stats_release got %0d exp 10", stall_cycles); end
    iss_ready = 1'b0;
    in_inst = mk(5'd1, 5'd2, 5'd8, 2'd0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (stall_cycles !== 16'd10) begin n_err++; $display("FAIL stats_bp got %0d exp 10", stall_cycles); end
    iss_ready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_raw();
    test_limit();
    test_same_cycle();
    test_backpressure();
    test_sb_err();
    test_reset_mid();
`ifdef FPU_SB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
